// File: rtl/leaf_pkt_pkg.sv
// Field layout and shared types for the 49-bit BFT leaf packet
// consumed by the receive-side demultiplexer.
package leaf_pkt_pkg;
    localparam int PKT_W   = 49;
    localparam int VLD_BIT = 48;
    localparam int ADDR_HI = 47;
    localparam int ADDR_LO = 43;
    localparam int PORT_HI = 42;
    localparam int PORT_LO = 40;
    localparam int DATA_HI = 31;
    localparam int DATA_LO = 0;
    localparam int ADDR_W  = 5;
    localparam int PORT_W  = 3;
    localparam int DATA_W  = 32;

    typedef enum logic [1:0] {
        DROP_NONE,
        DROP_ADDR,
        DROP_FULL
    } drop_cause_e;
endpackage

// File: rtl/leaf_rx_fifo.sv
// First-word-fall-through FIFO: rd_data shows the head word whenever
// empty is low; a push into a full FIFO is accepted only alongside a pop.
module leaf_rx_fifo
    import leaf_pkt_pkg::*;
#(
    parameter int DEPTH = 16
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              wr_en,
    input  logic [DATA_W-1:0] wr_data,
    output logic              full,
    input  logic              rd_en,
    output logic [DATA_W-1:0] rd_data,
    output logic              empty
);
    localparam int AW = $clog2(DEPTH);

    logic [DATA_W-1:0] mem [DEPTH];
    logic [AW:0]       wr_ptr_reg;
    logic [AW:0]       rd_ptr_reg;
    logic              do_wr;
    logic              do_rd;

    // Extra pointer MSB distinguishes full from empty when the indices match.
    assign empty   = (wr_ptr_reg == rd_ptr_reg);
    assign full    = (wr_ptr_reg[AW] != rd_ptr_reg[AW]) &&
                     (wr_ptr_reg[AW-1:0] == rd_ptr_reg[AW-1:0]);
    assign do_rd   = rd_en && !empty;
    assign do_wr   = wr_en && (!full || do_rd);
    assign rd_data = mem[rd_ptr_reg[AW-1:0]];

    always_ff @(posedge clk) begin
        if (do_wr) begin
            mem[wr_ptr_reg[AW-1:0]] <= wr_data;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr_reg <= '0;
            rd_ptr_reg <= '0;
        end else begin
            if (do_wr) wr_ptr_reg <= wr_ptr_reg + 1'b1;
            if (do_rd) rd_ptr_reg <= rd_ptr_reg + 1'b1;
        end
    end
endmodule

// File: rtl/leaf_rx_demux.sv
// Leaf receive stage: registers each BFT packet, filters on leaf address,
// and steers the payload into per-port FWFT FIFOs, reporting drops.
module leaf_rx_demux
    import leaf_pkt_pkg::*;
#(
    parameter logic [ADDR_W-1:0] LEAF_ID    = 5'd0,
    parameter int                NUM_PORTS  = 4,
    parameter int                FIFO_DEPTH = 16,
    parameter int                CNT_W      = 16
) (
    input  logic                        clk_400,
    input  logic                        reset_400,
    input  logic [PKT_W-1:0]            din_leaf_bft2interface,
    output logic [NUM_PORTS-1:0]        dout_valid,
    input  logic [NUM_PORTS-1:0]        dout_ready,
    output logic [DATA_W*NUM_PORTS-1:0] dout_data,
    output logic                        resend_req,
    output logic [PORT_W-1:0]           resend_port,
    output logic [CNT_W-1:0]            drop_addr_cnt,
    output logic [CNT_W-1:0]            drop_full_cnt
);
    logic              s1_vld_reg;
    logic [ADDR_W-1:0] s1_addr_reg;
    logic [PORT_W-1:0] s1_port_reg;
    logic [DATA_W-1:0] s1_data_reg;

    logic [NUM_PORTS-1:0] port_hit;
    logic [NUM_PORTS-1:0] fifo_full;
    logic [NUM_PORTS-1:0] fifo_empty;
    logic [NUM_PORTS-1:0] wr_en;
    logic                 blocked;
    drop_cause_e          cause;

    logic              resend_req_reg;
    logic [PORT_W-1:0] resend_port_reg;
    logic [CNT_W-1:0]  drop_addr_reg;
    logic [CNT_W-1:0]  drop_full_reg;

    // Reserved field carries nothing for this leaf.
    logic unused_rsvd;
    assign unused_rsvd = ^din_leaf_bft2interface[39:32];

    always_ff @(posedge clk_400 or posedge reset_400) begin
        if (reset_400) begin
            s1_vld_reg  <= 1'b0;
            s1_addr_reg <= '0;
            s1_port_reg <= '0;
            s1_data_reg <= '0;
        end else begin
            s1_vld_reg  <= din_leaf_bft2interface[VLD_BIT];
            s1_addr_reg <= din_leaf_bft2interface[ADDR_HI:ADDR_LO];
            s1_port_reg <= din_leaf_bft2interface[PORT_HI:PORT_LO];
            s1_data_reg <= din_leaf_bft2interface[DATA_HI:DATA_LO];
        end
    end

    // A full FIFO still accepts when its head is popped in the same cycle.
    assign blocked = |(port_hit & fifo_full & ~dout_ready);

    always_comb begin
        cause = DROP_NONE;
        if (s1_vld_reg) begin
            if (s1_addr_reg != LEAF_ID)            cause = DROP_ADDR;
            else if (int'(s1_port_reg) >= NUM_PORTS) cause = DROP_FULL;
            else if (blocked)                      cause = DROP_FULL;
        end
    end

    generate
        for (genvar gi = 0; gi < NUM_PORTS; gi++) begin : g_port
            assign port_hit[gi]   = (s1_port_reg == PORT_W'(gi));
            assign wr_en[gi]      = s1_vld_reg && (cause == DROP_NONE) && port_hit[gi];
            assign dout_valid[gi] = !fifo_empty[gi];

            leaf_rx_fifo #(
                .DEPTH (FIFO_DEPTH)
            ) u_fifo (
                .clk     (clk_400),
                .rst     (reset_400),
                .wr_en   (wr_en[gi]),
                .wr_data (s1_data_reg),
                .full    (fifo_full[gi]),
                .rd_en   (dout_ready[gi]),
                .rd_data (dout_data[DATA_W*gi +: DATA_W]),
                .empty   (fifo_empty[gi])
            );
        end
    endgenerate

    always_ff @(posedge clk_400 or posedge reset_400) begin
        if (reset_400) begin
            resend_req_reg  <= 1'b0;
            resend_port_reg <= '0;
            drop_addr_reg   <= '0;
            drop_full_reg   <= '0;
        end else begin
            resend_req_reg <= (cause != DROP_NONE);
            if (cause != DROP_NONE) resend_port_reg <= s1_port_reg;
            if (cause == DROP_ADDR && drop_addr_reg != {CNT_W{1'b1}})
                drop_addr_reg <= drop_addr_reg + CNT_W'(1);
            if (cause == DROP_FULL && drop_full_reg != {CNT_W{1'b1}})
                drop_full_reg <= drop_full_reg + CNT_W'(1);
        end
    end

    assign resend_req    = resend_req_reg;
    assign resend_port   = resend_port_reg;
    assign drop_addr_cnt = drop_addr_reg;
    assign drop_full_cnt = drop_full_reg;
endmodule

// File: tb/tb_leaf_rx_demux.sv
// Directed and randomized bench for leaf_rx_demux against a queue-based
// model of the packet steering, drop and counter rules.
module tb_leaf_rx_demux;
    localparam logic [4:0] LEAF_ID = 5'd9;
    localparam int NP     = 4;
    localparam int DEPTH  = 16;
    localparam int CNT_W  = 4;
    localparam int CNT_MAX = (1 << CNT_W) - 1;

    logic                 clk;
    logic                 rst;
    logic [48:0]          din;
    logic [NP-1:0]        dout_valid;
    logic [NP-1:0]        dout_ready;
    logic [32*NP-1:0]     dout_data;
    logic                 resend_req;
    logic [2:0]           resend_port;
    logic [CNT_W-1:0]     drop_addr_cnt;
    logic [CNT_W-1:0]     drop_full_cnt;

    leaf_rx_demux #(
        .LEAF_ID    (LEAF_ID),
        .NUM_PORTS  (NP),
        .FIFO_DEPTH (DEPTH),
        .CNT_W      (CNT_W)
    ) dut (
        .clk_400                (clk),
        .reset_400              (rst),
        .din_leaf_bft2interface (din),
        .dout_valid             (dout_valid),
        .dout_ready             (dout_ready),
        .dout_data              (dout_data),
        .resend_req             (resend_req),
        .resend_port            (resend_port),
        .drop_addr_cnt          (drop_addr_cnt),
        .drop_full_cnt          (drop_full_cnt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    // Reference state: per-port word queues, the packet waiting in the input
    // register, the expected drop report and the saturating drop counts.
    logic [31:0] q [NP][$];
    logic        pend_v;
    logic [4:0]  pend_addr;
    logic [2:0]  pend_port;
    logic [31:0] pend_data;
    logic        exp_req;
    logic [2:0]  exp_port;
    int          exp_addr_cnt;
    int          exp_full_cnt;
    int          seen_req;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic logic [48:0] mk(input logic [4:0] addr, input logic [2:0] port,
                                       input logic [31:0] data);
        logic [7:0] rsvd;
        rsvd = 8'($urandom);
        return {1'b1, addr, port, rsvd, data};
    endfunction

    task automatic check_outputs(input string tag);
        for (int p = 0; p < NP; p++) begin
            chk($sformatf("%s valid[%0d]", tag, p), 64'(dout_valid[p]), 64'(q[p].size() > 0));
            if (q[p].size() > 0)
                chk($sformatf("%s data[%0d]", tag, p), 64'(dout_data[32*p +: 32]), 64'(q[p][0]));
        end
        chk({tag, " resend_req"}, 64'(resend_req), 64'(exp_req));
        if (exp_req) chk({tag, " resend_port"}, 64'(resend_port), 64'(exp_port));
        chk({tag, " drop_addr_cnt"}, 64'(drop_addr_cnt), 64'(exp_addr_cnt));
        chk({tag, " drop_full_cnt"}, 64'(drop_full_cnt), 64'(exp_full_cnt));
    endtask

    task automatic step(input string tag, input logic [48:0] pkt, input logic [NP-1:0] rdy);
        int sz [NP];
        @(negedge clk);
        din        = pkt;
        dout_ready = rdy;
        for (int p = 0; p < NP; p++) sz[p] = q[p].size();
        for (int p = 0; p < NP; p++)
            if (sz[p] > 0 && rdy[p]) void'(q[p].pop_front());
        exp_req = 1'b0;
        if (pend_v) begin
            if (pend_addr != LEAF_ID) begin
                exp_req = 1'b1; exp_port = pend_port;
                if (exp_addr_cnt < CNT_MAX) exp_addr_cnt++;
            end else if (int'(pend_port) >= NP ||
                         (sz[pend_port] == DEPTH && !rdy[pend_port])) begin
                exp_req = 1'b1; exp_port = pend_port;
                if (exp_full_cnt < CNT_MAX) exp_full_cnt++;
            end else begin
                q[pend_port].push_back(pend_data);
            end
        end
        pend_v    = pkt[48];
        pend_addr = pkt[47:43];
        pend_port = pkt[42:40];
        pend_data = pkt[31:0];
        @(posedge clk);
        #1;
        if (resend_req) seen_req++;
        check_outputs(tag);
    endtask

    task automatic model_reset();
        for (int p = 0; p < NP; p++) q[p].delete();
        pend_v = 1'b0; exp_req = 1'b0; exp_port = '0;
        exp_addr_cnt = 0; exp_full_cnt = 0;
    endtask

    initial begin
        rst = 1'b1; din = '0; dout_ready = '0; seen_req = 0;
        model_reset();
        #1;
        check_outputs("reset");
        chk("reset resend_port", 64'(resend_port), 64'd0);
        repeat (3) @(posedge clk);
        @(negedge clk); rst = 1'b0;

        // Single packet to port 2; valid for exactly one cycle, two cycles later.
        step("single_in", mk(LEAF_ID, 3'd2, 32'hDEADBEEF), '1);
        chk("single lat1 valid", 64'(dout_valid), 64'd0);
        step("single_s1", '0, '1);
        chk("single lat2 valid", 64'(dout_valid), 64'b0100);
        chk("single data", 64'(dout_data[95:64]), 64'hDEADBEEF);
        step("single_pop", '0, '1);
        chk("single no resend", 64'(seen_req), 64'd0);

        // Leaf address mismatch.
        step("addr_in", mk(LEAF_ID ^ 5'd1, 3'd3, 32'h1234), '1);
        step("addr_s1", '0, '1);
        chk("addr resend_port", 64'(resend_port), 64'd3);
        step("addr_after", '0, '1);

        // Overfill port 0 with ready held low, then drain in order.
        for (int i = 0; i <= DEPTH; i++) step("fill", mk(LEAF_ID, 3'd0, 32'(i)), 4'b1110);
        step("fill_last", '0, 4'b1110);
        chk("fill drop_full_cnt", 64'(drop_full_cnt), 64'd1);
        for (int i = 0; i <= DEPTH; i++) step("drain", '0, '1);

        // Full FIFO keeps accepting while it is popped every cycle.
        for (int i = 0; i < DEPTH; i++) step("refill", mk(LEAF_ID, 3'd0, 32'(100 + i)), 4'b1110);
        for (int i = 0; i < 8; i++) step("flow", mk(LEAF_ID, 3'd0, 32'(200 + i)), '1);
        for (int i = 0; i <= DEPTH + 8; i++) step("flow_drain", '0, '1);

        // Port number beyond NUM_PORTS.
        step("port5_in", mk(LEAF_ID, 3'd5, 32'h55), '1);
        step("port5_s1", '0, '1);

        // Reset mid-burst: port 1 holds 5 words and a packet sits in S1.
        for (int i = 0; i < 5; i++) step("preload", mk(LEAF_ID, 3'd1, 32'(300 + i)), 4'b1101);
        step("inflight", mk(LEAF_ID ^ 5'd2, 3'd1, 32'hBAD), 4'b1101);
        #2 rst = 1'b1;
        model_reset();
        #1;
        check_outputs("async_reset");
        chk("async_reset resend_port", 64'(resend_port), 64'd0);
        @(negedge clk); din = '0; rst = 1'b0;
        step("post_reset_idle", '0, '1);
        step("post_reset_in", mk(LEAF_ID, 3'd1, 32'hC0FFEE), '1);
        step("post_reset_s1", '0, '1);
        step("post_reset_pop", '0, '1);

        // Randomized traffic: sparse ready first to force drops and saturation.
        for (int i = 0; i < 600; i++) begin
            logic [48:0]   pkt;
            logic [NP-1:0] rdy;
            logic [4:0]    addr;
            addr = ($urandom_range(0, 9) == 0) ? 5'($urandom) : LEAF_ID;
            pkt  = ($urandom_range(0, 9) < 7)
                 ? mk(addr, 3'($urandom_range(0, 4)), $urandom) : 49'd0;
            for (int p = 0; p < NP; p++)
                rdy[p] = (i < 300) ? ($urandom_range(0, 9) < 3) : ($urandom_range(0, 9) < 8);
            step("random", pkt, rdy);
        end
        for (int i = 0; i < DEPTH + 2; i++) step("final_drain", '0, '1);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
